// File: rtl/riscv_pkg.sv
// Package riscv: shared RV32I decode types.
// Holds opcode constants, ALU operation encoding, operand-select enums,
// immediate-format enum and the funct3/funct7 -> ALU-op helper.
package riscv;

   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] data_t;
   typedef logic [4:0]      reg_idx_t;

   // ALU operations; FUN_ADD is encoded as zero so the cleared state is ADD
   typedef enum logic [3:0] {
      FUN_ADD  = 4'd0,
      FUN_SUB  = 4'd1,
      FUN_SLL  = 4'd2,
      FUN_SLT  = 4'd3,
      FUN_SLTU = 4'd4,
      FUN_XOR  = 4'd5,
      FUN_SRL  = 4'd6,
      FUN_SRA  = 4'd7,
      FUN_OR   = 4'd8,
      FUN_AND  = 4'd9
   } funct_t;

   typedef enum logic [1:0] {
      OP1_RS1  = 2'd0,
      OP1_PC   = 2'd1,
      OP1_ZERO = 2'd2
   } op1_sel_t;

   typedef enum logic {
      OP2_RS2 = 1'b0,
      OP2_IMM = 1'b1
   } op2_sel_t;

   typedef enum logic [2:0] {
      IMM_NONE  = 3'd0,
      IMM_I     = 3'd1,
      IMM_S     = 3'd2,
      IMM_B     = 3'd3,
      IMM_U     = 3'd4,
      IMM_J     = 3'd5,
      IMM_SHAMT = 3'd6
   } imm_fmt_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // Map funct3 plus the alternate bit (funct7[5]) onto an ALU operation
   function automatic funct_t alu_fun(input logic [2:0] funct3, input logic alt);
      funct_t f;
      case (funct3)
         3'b000:  f = alt ? FUN_SUB : FUN_ADD;
         3'b001:  f = FUN_SLL;
         3'b010:  f = FUN_SLT;
         3'b011:  f = FUN_SLTU;
         3'b100:  f = FUN_XOR;
         3'b101:  f = alt ? FUN_SRA : FUN_SRL;
         3'b110:  f = FUN_OR;
         default: f = FUN_AND;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/decode_immgen.sv
// immgen: combinational RV32I immediate extraction.
// Produces the sign-extended (or zero-extended shamt) immediate for the
// selected instruction format; IMM_NONE yields zero.
module immgen
   import riscv::*;
(
   input  logic [31:0] inst,
   input  imm_fmt_t    format,
   output data_t       imm
);

   // Reassemble the scattered immediate bits of each encoding format
   always_comb begin
      case (format)
         IMM_I:     imm = {{20{inst[31]}}, inst[31:20]};
         IMM_S:     imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B:     imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_U:     imm = {inst[31:12], 12'b0};
         IMM_J:     imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         IMM_SHAMT: imm = {27'b0, inst[24:20]};
         default:   imm = '0;
      endcase
   end

endmodule

// File: rtl/decode.sv
// decode: single-stage RV32I instruction decoder with valid/ready handshake.
// One-cycle latency, full throughput, stall-holding outputs, flush and
// asynchronous active-high reset. Define DECODE_ILLEGAL_EN to add the
// out_illegal port; without it illegal instructions decode silently as a NOP.
module decode
   import riscv::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_inst,
   input  data_t       in_pc,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output funct_t      out_fun,
   output op1_sel_t    out_op1_sel,
   output op2_sel_t    out_op2_sel,
   output data_t       out_imm,
   output reg_idx_t    out_rs1,
   output reg_idx_t    out_rs2,
   output reg_idx_t    out_rd,
   output logic        out_rd_we,
   output logic        out_mem_rd,
   output logic        out_mem_wr,
   output logic        out_jump,
   output logic        out_branch,
   output data_t       out_pc
`ifdef DECODE_ILLEGAL_EN
   ,
   output logic        out_illegal
`endif
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   reg_idx_t   rd;
   logic       accept;

   assign opcode = in_inst[6:0];
   assign funct3 = in_inst[14:12];
   assign funct7 = in_inst[31:25];
   assign rd     = in_inst[11:7];

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   funct_t   d_fun;
   op1_sel_t d_op1;
   op2_sel_t d_op2;
   imm_fmt_t d_fmt;
   data_t    d_imm;
   logic     d_rd_we;
   logic     d_mem_rd;
   logic     d_mem_wr;
   logic     d_jump;
   logic     d_branch;
   logic     d_illegal;

   immgen u_immgen (
      .inst   (in_inst),
      .format (d_fmt),
      .imm    (d_imm)
   );

   // Classify the incoming instruction into ALU op, operand sources and control flags
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      d_fun     = FUN_ADD;
      d_op1     = OP1_RS1;
      d_op2     = OP2_RS2;
      d_fmt     = IMM_NONE;
      d_rd_we   = 1'b0;
      d_mem_rd  = 1'b0;
      d_mem_wr  = 1'b0;
      d_jump    = 1'b0;
      d_branch  = 1'b0;
      d_illegal = 1'b0;
      case (opcode)
         OPC_OP: begin
            d_fun   = alu_fun(funct3, funct7[5]);
            d_rd_we = 1'b1;
            d_illegal = !((funct7 == F7_BASE) ||
                          (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
         end
         OPC_OP_IMM: begin
            d_op2   = OP2_IMM;
            d_rd_we = 1'b1;
            if (funct3 == 3'b001) begin
               d_fun     = FUN_SLL;
               d_fmt     = IMM_SHAMT;
               d_illegal = (funct7 != F7_BASE);
            end else if (funct3 == 3'b101) begin
               d_fun     = alu_fun(funct3, funct7[5]);
               d_fmt     = IMM_SHAMT;
               d_illegal = !(funct7 == F7_BASE || funct7 == F7_ALT);
            end else begin
               // funct7 bits belong to the immediate here, so SUB is never selected
               d_fun = alu_fun(funct3, 1'b0);
               d_fmt = IMM_I;
            end
         end
         OPC_LUI: begin
            d_op1   = OP1_ZERO;
            d_op2   = OP2_IMM;
            d_fmt   = IMM_U;
            d_rd_we = 1'b1;
         end
         OPC_AUIPC: begin
            d_op1   = OP1_PC;
            d_op2   = OP2_IMM;
            d_fmt   = IMM_U;
            d_rd_we = 1'b1;
         end
         OPC_JAL: begin
            d_op1   = OP1_PC;
            d_op2   = OP2_IMM;
            d_fmt   = IMM_J;
            d_rd_we = 1'b1;
            d_jump  = 1'b1;
         end
         OPC_JALR: begin
            d_op2     = OP2_IMM;
            d_fmt     = IMM_I;
            d_rd_we   = 1'b1;
            d_jump    = 1'b1;
            d_illegal = (funct3 != 3'b000);
         end
         OPC_BRANCH: begin
            d_fmt    = IMM_B;
            d_branch = 1'b1;
            case (funct3)
               3'b000, 3'b001: d_fun = FUN_SUB;
               3'b100, 3'b101: d_fun = FUN_SLT;
               3'b110, 3'b111: d_fun = FUN_SLTU;
               default:        d_illegal = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            d_op2     = OP2_IMM;
            d_fmt     = IMM_I;
            d_rd_we   = 1'b1;
            d_mem_rd  = 1'b1;
            d_illegal = (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
         end
         OPC_STORE: begin
            d_op2     = OP2_IMM;
            d_fmt     = IMM_S;
            d_mem_wr  = 1'b1;
            d_illegal = (funct3 > 3'b010);
         end
         default: d_illegal = 1'b1;
      endcase
      // An illegal instruction collapses to a side-effect-free NOP
      if (d_illegal) begin
         d_fun    = FUN_ADD;
         d_op1    = OP1_RS1;
         d_op2    = OP2_RS2;
         d_fmt    = IMM_NONE;
         d_rd_we  = 1'b0;
         d_mem_rd = 1'b0;
         d_mem_wr = 1'b0;
         d_jump   = 1'b0;
         d_branch = 1'b0;
      end
      // Writes to x0 are discarded
      if (rd == 5'd0) d_rd_we = 1'b0;
   end

   // Output bundle register: load on accept, hold while stalled, drop on flush
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) begin
         out_valid   <= 1'b0;
         out_fun     <= FUN_ADD;
         out_op1_sel <= OP1_RS1;
         out_op2_sel <= OP2_RS2;
         out_imm     <= '0;
         out_rs1     <= '0;
         out_rs2     <= '0;
         out_rd      <= '0;
         out_rd_we   <= 1'b0;
         out_mem_rd  <= 1'b0;
         out_mem_wr  <= 1'b0;
         out_jump    <= 1'b0;
         out_branch  <= 1'b0;
         out_pc      <= '0;
`ifdef DECODE_ILLEGAL_EN
         out_illegal <= 1'b0;
`endif
      end else begin
         if (flush)          out_valid <= 1'b0;
         else if (accept)    out_valid <= 1'b1;
         else if (out_ready) out_valid <= 1'b0;

         if (accept && !flush) begin
            out_fun     <= d_fun;
            out_op1_sel <= d_op1;
            out_op2_sel <= d_op2;
            out_imm     <= d_imm;
            out_rs1     <= in_inst[19:15];
            out_rs2     <= in_inst[24:20];
            out_rd      <= rd;
            out_rd_we   <= d_rd_we;
            out_mem_rd  <= d_mem_rd;
            out_mem_wr  <= d_mem_wr;
            out_jump    <= d_jump;
            out_branch  <= d_branch;
            out_pc      <= in_pc;
`ifdef DECODE_ILLEGAL_EN
            out_illegal <= d_illegal;
`endif
         end
      end
   end

endmodule

// File: tb/tb_decode.sv
// tb_decode: table-driven self-checking bench for decode, plus directed
// sequences for stall, flush and asynchronous reset mid-stall.
module tb_decode;
   import riscv::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   data_t       in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   funct_t      out_fun;
   op1_sel_t    out_op1_sel;
   op2_sel_t    out_op2_sel;
   data_t       out_imm;
   reg_idx_t    out_rs1, out_rs2, out_rd;
   logic        out_rd_we, out_mem_rd, out_mem_wr, out_jump, out_branch;
   data_t       out_pc;
`ifdef DECODE_ILLEGAL_EN
   logic        out_illegal;
`endif

   int checks   = 0;
   int failures = 0;

   decode dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_inst     (in_inst),
      .in_pc       (in_pc),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_fun     (out_fun),
      .out_op1_sel (out_op1_sel),
      .out_op2_sel (out_op2_sel),
      .out_imm     (out_imm),
      .out_rs1     (out_rs1),
      .out_rs2     (out_rs2),
      .out_rd      (out_rd),
      .out_rd_we   (out_rd_we),
      .out_mem_rd  (out_mem_rd),
      .out_mem_wr  (out_mem_wr),
      .out_jump    (out_jump),
      .out_branch  (out_branch),
      .out_pc      (out_pc)
`ifdef DECODE_ILLEGAL_EN
      ,
      .out_illegal (out_illegal)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      funct_t      fun;
      logic        chk_sel;
      op1_sel_t    op1;
      op2_sel_t    op2;
      logic        chk_imm;
      logic [31:0] imm;
      logic [4:0]  rs1, rs2, rd;
      logic        rd_we, mem_rd, mem_wr, jump, branch, illegal;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] pc, input funct_t fun,
                               input logic chk_sel, input op1_sel_t op1, input op2_sel_t op2,
                               input logic chk_imm, input logic [31:0] imm,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic rd_we, input logic mem_rd, input logic mem_wr,
                               input logic jump, input logic branch, input logic illegal);
      vec_t v;
      v.inst = inst; v.pc = pc; v.fun = fun; v.chk_sel = chk_sel; v.op1 = op1; v.op2 = op2;
      v.chk_imm = chk_imm; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
      v.rd_we = rd_we; v.mem_rd = mem_rd; v.mem_wr = mem_wr; v.jump = jump;
      v.branch = branch; v.illegal = illegal;
      return v;
   endfunction

   task automatic check_vec(input vec_t v, input int idx);
      string p;
      p = $sformatf("v%0d_%08h", idx, v.inst);
      check({p, "_valid"}, 32'(out_valid), 32'd1);
      check({p, "_fun"}, 32'(out_fun), 32'(v.fun));
      if (v.chk_sel) begin
         check({p, "_op1"}, 32'(out_op1_sel), 32'(v.op1));
         check({p, "_op2"}, 32'(out_op2_sel), 32'(v.op2));
      end
      if (v.chk_imm) check({p, "_imm"}, out_imm, v.imm);
      check({p, "_rs1"}, 32'(out_rs1), 32'(v.rs1));
      check({p, "_rs2"}, 32'(out_rs2), 32'(v.rs2));
      check({p, "_rd"}, 32'(out_rd), 32'(v.rd));
      check({p, "_flags"}, {27'b0, out_rd_we, out_mem_rd, out_mem_wr, out_jump, out_branch},
            {27'b0, v.rd_we, v.mem_rd, v.mem_wr, v.jump, v.branch});
      check({p, "_pc"}, out_pc, v.pc);
`ifdef DECODE_ILLEGAL_EN
      check({p, "_illegal"}, 32'(out_illegal), 32'(v.illegal));
`endif
   endtask

   task automatic check_cleared(input string name);
      check({name, "_valid"}, 32'(out_valid), 32'd0);
      check({name, "_fun"}, 32'(out_fun), 32'(FUN_ADD));
      check({name, "_imm"}, out_imm, 32'd0);
      check({name, "_rd"}, 32'(out_rd), 32'd0);
      check({name, "_sel"}, {29'b0, out_op1_sel, out_op2_sel}, 32'd0);
      check({name, "_flags"}, {27'b0, out_rd_we, out_mem_rd, out_mem_wr, out_jump, out_branch}, 32'd0);
      check({name, "_pc"}, out_pc, 32'd0);
`ifdef DECODE_ILLEGAL_EN
      check({name, "_illegal"}, 32'(out_illegal), 32'd0);
`endif
   endtask

   initial begin
      //        inst          pc            fun       sel op1       op2      imm? imm           rs1 rs2 rd  we rd wr jp br il
      vecs.push_back(mk(32'h002081B3, 32'h00000100, FUN_ADD,  1, OP1_RS1,  OP2_RS2, 0, 32'h0,        1,  2,  3,  1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(32'h4032D293, 32'h00000104, FUN_SRA,  1, OP1_RS1,  OP2_IMM, 1, 32'h3,        5,  3,  5,  1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(32'h123450B7, 32'h00000108, FUN_ADD,  1, OP1_ZERO, OP2_IMM, 1, 32'h12345000, 8,  3,  1,  1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(32'h40208233, 32'h0000010C, FUN_SUB,  1, OP1_RS1,  OP2_RS2, 0, 32'h0,        1,  2,  4,  1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(32'h00001117, 32'h00000110, FUN_ADD,  1, OP1_PC,   OP2_IMM, 1, 32'h00001000, 0,  0,  2,  1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(32'h008000EF, 32'h00000114, FUN_ADD,  1, OP1_PC,   OP2_IMM, 1, 32'h8,        0,  8,  1,  1, 0, 0, 1, 0, 0));
      vecs.push_back(mk(32'h00008067, 32'h00000118, FUN_ADD,  1, OP1_RS1,  OP2_IMM, 1, 32'h0,        1,  0,  0,  0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(32'hFE208EE3, 32'h0000011C, FUN_SUB,  1, OP1_RS1,  OP2_RS2, 1, 32'hFFFFFFFC, 1,  2,  29, 0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(32'h0020E463, 32'h00000120, FUN_SLTU, 1, OP1_RS1,  OP2_RS2, 1, 32'h8,        1,  2,  8,  0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(32'hFFF12283, 32'h00000124, FUN_ADD,  1, OP1_RS1,  OP2_IMM, 1, 32'hFFFFFFFF, 2,  31, 5,  1, 1, 0, 0, 0, 0));
      vecs.push_back(mk(32'h00612A23, 32'h00000128, FUN_ADD,  1, OP1_RS1,  OP2_IMM, 1, 32'h14,       2,  6,  20, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(32'hFFE0B393, 32'h0000012C, FUN_SLTU, 1, OP1_RS1,  OP2_IMM, 1, 32'hFFFFFFFE, 1,  30, 7,  1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(32'h00208033, 32'h00000130, FUN_ADD,  1, OP1_RS1,  OP2_RS2, 0, 32'h0,        1,  2,  0,  0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(32'hFFFFFFFF, 32'h00000134, FUN_ADD,  0, OP1_RS1,  OP2_RS2, 0, 32'h0,        31, 31, 31, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(32'h40009093, 32'h00000138, FUN_ADD,  0, OP1_RS1,  OP2_RS2, 0, 32'h0,        1,  0,  1,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(32'h022081B3, 32'h0000013C, FUN_ADD,  0, OP1_RS1,  OP2_RS2, 0, 32'h0,        1,  2,  3,  0, 0, 0, 0, 0, 1));

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_inst   = 32'h0;
      in_pc     = 32'h0;
      flush     = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      check_cleared("reset");
      check("reset_in_ready", 32'(in_ready), 32'd1);

      // Release reset and present the first instruction in the same cycle;
      // then stream the table back-to-back with out_ready held high.
      reset = 1'b0;
      for (int i = 0; i < vecs.size(); i++) begin
         in_valid = 1'b1;
         in_inst  = vecs[i].inst;
         in_pc    = vecs[i].pc;
         step();
         check_vec(vecs[i], i);
      end
      in_valid = 1'b0;
      step();
      check("drain_valid", 32'(out_valid), 32'd0);

      // Stall: A accepted, B waits three cycles while out_ready is low
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_inst   = vecs[0].inst;
      in_pc     = 32'h00000200;
      step();
      in_inst = vecs[1].inst;
      in_pc   = 32'h00000204;
      check("stall_a_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      for (int c = 0; c < 3; c++) begin
         step();
         check($sformatf("stall%0d_valid", c), 32'(out_valid), 32'd1);
         check($sformatf("stall%0d_rd", c), 32'(out_rd), 32'd3);
         check($sformatf("stall%0d_fun", c), 32'(out_fun), 32'(FUN_ADD));
         check($sformatf("stall%0d_pc", c), out_pc, 32'h00000200);
         check($sformatf("stall%0d_in_ready", c), 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      #1;
      check("unstall_in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      check("second_valid", 32'(out_valid), 32'd1);
      check("second_fun", 32'(out_fun), 32'(FUN_SRA));
      check("second_rd", 32'(out_rd), 32'd5);
      check("second_imm", out_imm, 32'd3);
      check("second_pc", out_pc, 32'h00000204);
      step();
      check("second_drain", 32'(out_valid), 32'd0);

      // Flush while stalled with a valid bundle and a new instruction offered
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_inst   = vecs[2].inst;
      in_pc     = 32'h00000300;
      step();
      check("pre_flush_valid", 32'(out_valid), 32'd1);
      flush   = 1'b1;
      in_inst = vecs[3].inst;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_valid", 32'(out_valid), 32'd0);
      step();
      check("flush_dropped", 32'(out_valid), 32'd0);

      // Reset asserted mid-stall clears the bundle before the next clock edge
      in_valid = 1'b1;
      in_inst  = vecs[5].inst;
      in_pc    = 32'h00000400;
      step();
      in_valid = 1'b0;
      check("pre_reset_valid", 32'(out_valid), 32'd1);
      check("pre_reset_jump", 32'(out_jump), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check_cleared("async_reset");
      #1;
      reset = 1'b0;
      step();
      check("post_reset_valid", 32'(out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 SHALL have no parameters; all widths come from the riscv package.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 in_valid  in  1  fetch presents an instruction.
REQ-006 in_ready  out  1  decode accepts this cycle.
REQ-007 in_inst  in  32  RV32I instruction word.
REQ-008 in_pc  in  data_t  PC of in_inst.
REQ-009 flush  in  1  discard held and incoming instruction.
REQ-010 out_valid  out  1  decoded bundle valid.
REQ-011 out_ready  in  1  execute consumes the bundle.
REQ-012 out_fun  out  funct_t  ALU operation.
REQ-013 out_op1_sel  out  2  ALU op1 source: RS1, PC or ZERO.
REQ-014 out_op2_sel  out  1  ALU op2 source: RS2 or IMM.
REQ-015 out_imm  out  data_t  sign-extended immediate.
REQ-016 out_rs1, out_rs2, out_rd  out  5 each  register indices.
REQ-017 out_rd_we  out  1  register writeback enable.
REQ-018 out_mem_rd, out_mem_wr, out_jump  out  1 each  load, store and jump flags.
REQ-019 out_branch  out  1  conditional branch flag.
REQ-020 out_pc  out  data_t  registered in_pc.

Function
REQ-021 in_ready SHALL equal !out_valid || out_ready; accept = in_valid && in_ready.
REQ-022 On accept, all decoded outputs SHALL register on the next rising edge, with out_valid=1 (latency 1 cycle).
REQ-023 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-024 Simultaneous consume and accept SHALL replace the bundle with no bubble, giving full throughput.
REQ-025 flush SHALL clear out_valid next edge, overriding accept; the flushed-cycle instruction is dropped.
REQ-026 OP: out_fun from funct3 and funct7[5] (ADD/SUB, SRL/SRA); op1=RS1, op2=RS2.
REQ-027 OP-IMM: out_fun from funct3; for SRAI, funct7[5] SHALL select SRA; for SLLI/SRLI/SRAI, out_imm = shamt zero-extended; op2=IMM.
REQ-028 LUI: ADD, op1=ZERO, out_imm = inst[31:12]<<12. AUIPC: ADD, op1=PC.
REQ-029 JAL/JALR: ADD, out_jump=1, out_rd_we=1; target computed as PC+imm (JAL) or RS1+imm (JALR).
REQ-030 BRANCH: out_branch=1; out_fun SHALL be SUB for BEQ/BNE, SLT for BLT/BGE and SLTU for BLTU/BGEU; out_rd_we=0.
REQ-031 LOAD/STORE: ADD, op1=RS1, op2=IMM, with the I- or S-format immediate respectively.
REQ-032 rd=x0 SHALL force out_rd_we=0.
REQ-033 Unknown opcode, or an unlisted funct3/funct7 combination, is illegal: out_fun=ADD, out_rd_we=0, out_mem_rd=0, out_mem_wr=0, out_jump=0, out_branch=0.

Reset
REQ-034 reset SHALL clear out_valid immediately, asynchronously, including mid-stall.
REQ-035 On reset, out_rd_we, out_mem_rd, out_mem_wr, out_jump, out_branch and out_illegal SHALL be 0; out_fun SHALL be ADD; all other outputs SHALL be 0.
REQ-036 The first accept after reset deassertion SHALL be permitted in the first clock cycle.

Configuration
REQ-037 Macro DECODE_ILLEGAL_EN SHALL control illegal-instruction reporting.
REQ-038 With DECODE_ILLEGAL_EN defined, port out_illegal (out, 1) SHALL be present and SHALL be 1 for an illegal instruction.
REQ-039 Without DECODE_ILLEGAL_EN, there SHALL be no out_illegal port; illegal instructions SHALL decode silently as the NOP of REQ-033.

Structure
REQ-040 Opcode constants, the op1_sel_t/op2_sel_t enums and the immediate-format enum SHALL live in package riscv; funct_t and data_t SHALL be reused from it.
REQ-041 Immediate extraction SHALL be a combinational sub-module named immgen (inputs: inst and format; output: data_t).

Verification
REQ-042 Directed scenarios the bench SHALL cover:
- 0x002081B3 (ADD x3,x1,x2) -> 1 cycle later: fun=ADD, rs1=1, rs2=2, rd=3, rd_we=1, op2=RS2.
- 0x4032D293 (SRAI x5,x5,3) -> fun=SRA, imm=3, op2=IMM, rd=5.
- 0x123450B7 (LUI x1,0x12345) -> fun=ADD, op1=ZERO, imm=0x12345000.
- Two back-to-back instructions with out_ready=0 for 3 cycles -> in_ready=0, first bundle stable; second appears the cycle after out_ready=1.
- flush while stalled with valid bundle -> out_valid=0 next cycle; reset asserted mid-stall -> out_valid=0 asynchronously.
- 0xFFFFFFFF -> rd_we=0, mem_wr=0; out_illegal=1 when DECODE_ILLEGAL_EN is defined.
